// File: rtl/xbar_tile_ctrl_if.sv
// Sequencer/crossbar-facing signal bundle for the tile controller.
// The master side drives requests and crossbar status; the slave side is the controller.
interface xbar_tile_ctrl_if #(
    parameter int NUM_DST = 4,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [CNT_W-1:0]   num_cycles;
    logic               abort;
    logic               xbar_busy;
    logic [NUM_DST-1:0] xbar_out_valid;
    logic               ready;
    logic               pe_en;
    logic               tile_done;
    logic               drain_err;
    logic [CNT_W-1:0]   stall_cycles;

    modport master (
        output start, num_cycles, abort, xbar_busy, xbar_out_valid,
        input  ready, pe_en, tile_done, drain_err, stall_cycles
    );

    modport slave (
        input  start, num_cycles, abort, xbar_busy, xbar_out_valid,
        output ready, pe_en, tile_done, drain_err, stall_cycles
    );
endinterface

// File: rtl/xbar_tile_ctrl.sv
// Tile sequencer: issues N enabled product cycles under crossbar backpressure,
// waits for the crossbar output FIFOs to drain and stay quiet, then pulses done.
module xbar_tile_ctrl #(
    parameter int NUM_DST   = 4,
    parameter int CNT_W     = 16,
    parameter int QUIET     = 2,
    parameter int MAX_DRAIN = 64
) (
    input logic             clock,
    input logic             reset,
    xbar_tile_ctrl_if.slave ctl
);
    localparam int QW = $clog2(QUIET + 1);
    localparam int DW = $clog2(MAX_DRAIN + 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAX_DRAIN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] issue_q, issue_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             err_q, err_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             pe_en, tile_done, ready, ov_zero;
    logic [CNT_W-1:0] n_last;

    assign n_last  = n_q - 1'b1;
    assign ov_zero = (ctl.xbar_out_valid == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            issue_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            quiet_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            issue_q <= issue_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            quiet_q <= quiet_d;
            drain_q <= drain_d;
        end
    end

    // Drain counters default to zero so they are clean on every entry to DRAIN.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        issue_d   = issue_q;
        stall_d   = stall_q;
        err_d     = err_q;
        quiet_d   = '0;
        drain_d   = '0;
        pe_en     = 1'b0;
        tile_done = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (ctl.start) begin
                    n_d     = ctl.num_cycles;
                    issue_d = '0;
                    stall_d = '0;
                    err_d   = 1'b0;
                    state_d = (ctl.num_cycles != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (ctl.abort) begin
                    state_d = IDLE;
                end else if (ctl.xbar_busy) begin
                    if (stall_q != '1) stall_d = stall_q + 1'b1;
                end else begin
                    pe_en   = 1'b1;
                    issue_d = issue_q + 1'b1;
                    if (issue_q == n_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ctl.abort) begin
                    state_d = IDLE;
                end else begin
                    quiet_d = ov_zero ? quiet_q + 1'b1 : '0;
                    drain_d = drain_q + 1'b1;
                    // Quiet completion takes priority over a coincident timeout.
                    if (ov_zero && quiet_q == QUIET_LAST) begin
                        state_d = DONE;
                    end else if (drain_q == DRAIN_LAST) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                tile_done = !ctl.abort;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ctl.ready        = ready;
    assign ctl.pe_en        = pe_en;
    assign ctl.tile_done    = tile_done;
    assign ctl.drain_err    = err_q;
    assign ctl.stall_cycles = stall_q;
endmodule

// File: tb/tb_xbar_tile_ctrl.sv
// Scoreboard bench: each tile's outcome is predicted from per-cycle stimulus tables,
// and a negedge monitor compares it when the controller returns to ready.
module tb_xbar_tile_ctrl;
    localparam int NUM_DST   = 4;
    localparam int CNT_W     = 16;
    localparam int QUIET     = 2;
    localparam int MAX_DRAIN = 64;
    localparam int MAXC      = 256;

    typedef struct {
        int end_cyc;
        int done_cyc;
        int pe_cnt;
        int stall;
        int err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    xbar_tile_ctrl_if #(.NUM_DST(NUM_DST), .CNT_W(CNT_W)) ctl ();
    xbar_tile_ctrl #(.NUM_DST(NUM_DST), .CNT_W(CNT_W), .QUIET(QUIET), .MAX_DRAIN(MAX_DRAIN))
        dut (.clock(clock), .reset(reset), .ctl(ctl));

    exp_t               sbq[$];
    int                 checks = 0;
    int                 errors = 0;
    logic               busy_a [MAXC];
    logic               start_a[MAXC];
    logic [NUM_DST-1:0] ov_a   [MAXC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_arrays();
        for (int i = 0; i < MAXC; i++) begin
            busy_a[i]  = 1'b0;
            start_a[i] = 1'b0;
            ov_a[i]    = '0;
        end
    endtask

    // Cycle k is the period whose inputs are sampled at edge k; start is sampled at edge 0.
    task automatic run_tile(input int n, input int a, input int r, input bit abort0);
        exp_t e;
        int   s, k, en, stall, dd, lim, pe;
        bit   tmo, ok;
        if (a > 0) busy_a[a] = 1'b0;
        s = 1;
        if (n > 0) begin
            en = 0;
            k  = 1;
            while (en < n && k < MAXC - MAX_DRAIN - 2) begin
                if (!busy_a[k]) en++;
                k++;
            end
            s = k;
        end
        stall = 0;
        for (int i = 1; i < s; i++) if (busy_a[i]) stall++;
        tmo = 1'b1;
        dd  = s + MAX_DRAIN;
        for (int j = QUIET - 1; j < MAX_DRAIN; j++) begin
            ok = 1'b1;
            for (int q = 0; q < QUIET; q++) if (ov_a[s + j - q] != '0) ok = 1'b0;
            if (ok) begin
                dd  = s + j + 1;
                tmo = 1'b0;
                break;
            end
        end
        e.end_cyc  = dd;
        e.done_cyc = dd;
        e.pe_cnt   = n;
        e.stall    = stall;
        e.err      = tmo ? 1 : 0;
        if (a > 0 && a <= dd) begin
            lim = (a < s) ? a : s;
            pe  = 0;
            stall = 0;
            for (int i = 1; i < lim; i++) if (busy_a[i]) stall++; else pe++;
            e.end_cyc  = a;
            e.done_cyc = -1;
            e.pe_cnt   = pe;
            e.stall    = stall;
            e.err      = (tmo && a == dd) ? 1 : 0;
        end else if (r > 0 && r <= dd) begin
            e.end_cyc  = r;
            e.done_cyc = -1;
            e.stall    = 0;
            e.err      = 0;
        end
        sbq.push_back(e);
        for (int c = 0; c <= e.end_cyc; c++) begin
            ctl.start          = (c == 0) || start_a[c];
            ctl.num_cycles     = (c == 0) ? CNT_W'(n) : CNT_W'($urandom);
            ctl.abort          = (a > 0 && c == a) || (c == 0 && abort0);
            ctl.xbar_busy      = busy_a[c];
            ctl.xbar_out_valid = ov_a[c];
            reset              = (r > 0 && c == r);
            @(posedge clock);
            #1;
        end
        ctl.start          = 1'b0;
        ctl.abort          = 1'b0;
        ctl.xbar_busy      = 1'b0;
        ctl.xbar_out_valid = '0;
        reset              = 1'b0;
        repeat (1 + $urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
        end
    endtask

    bit   m_active = 1'b0;
    int   m_cyc, m_pe, m_dcnt, m_dcyc;
    int   m_prev_stall = 0;
    int   m_prev_err = 0;
    exp_t m_e;

    always @(negedge clock) begin
        if (m_active) begin
            m_cyc++;
            if (ctl.pe_en) m_pe++;
            if (ctl.tile_done) begin
                m_dcnt++;
                m_dcyc = m_cyc;
            end
            if (ctl.ready) begin
                m_active = 1'b0;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    m_e = sbq.pop_front();
                    chk("end_cycle", m_cyc, m_e.end_cyc + 1);
                    chk("pe_en_cycles", m_pe, m_e.pe_cnt);
                    chk("done_pulses", m_dcnt, (m_e.done_cyc >= 0) ? 1 : 0);
                    if (m_e.done_cyc >= 0) chk("done_cycle", m_dcyc, m_e.done_cyc);
                    chk("stall_cycles", int'(ctl.stall_cycles), m_e.stall);
                    chk("drain_err", int'(ctl.drain_err), m_e.err);
                    m_prev_stall = m_e.stall;
                    m_prev_err   = m_e.err;
                end
            end
        end else if (m_cyc > MAXC) begin
            m_cyc = 0;
        end
        if (!m_active && ctl.ready && ctl.start && !reset) begin
            chk("held_stall", int'(ctl.stall_cycles), m_prev_stall);
            chk("held_err", int'(ctl.drain_err), m_prev_err);
            m_active = 1'b1;
            m_cyc    = 0;
            m_pe     = 0;
            m_dcnt   = 0;
            m_dcyc   = -1;
        end
    end

    initial begin
        int n, a;
        bit stuck;
        reset              = 1'b1;
        ctl.start          = 1'b0;
        ctl.num_cycles     = '0;
        ctl.abort          = 1'b0;
        ctl.xbar_busy      = 1'b0;
        ctl.xbar_out_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_ready", int'(ctl.ready), 1);
        chk("rst_pe_en", int'(ctl.pe_en), 0);
        chk("rst_tile_done", int'(ctl.tile_done), 0);
        chk("rst_stall", int'(ctl.stall_cycles), 0);
        chk("rst_drain_err", int'(ctl.drain_err), 0);

        clear_arrays();
        run_tile(3, 0, 0, 1'b0);

        clear_arrays();
        busy_a[2] = 1'b1;
        busy_a[3] = 1'b1;
        run_tile(4, 0, 0, 1'b0);

        clear_arrays();
        for (int i = 2; i <= 4; i++) ov_a[i] = 4'b0010;
        ov_a[6] = 4'b1000;
        run_tile(1, 0, 0, 1'b0);

        clear_arrays();
        for (int i = 2; i < MAXC; i++) ov_a[i] = 4'b0001;
        run_tile(1, 0, 0, 1'b0);

        clear_arrays();
        run_tile(0, 0, 0, 1'b1);

        clear_arrays();
        start_a[3] = 1'b1;
        run_tile(10, 6, 0, 1'b0);

        clear_arrays();
        busy_a[1] = 1'b1;
        for (int i = 4; i < MAXC; i++) ov_a[i] = 4'b0100;
        run_tile(2, 0, 6, 1'b0);

        for (int t = 0; t < 40; t++) begin
            clear_arrays();
            n     = $urandom_range(0, 20);
            stuck = ($urandom_range(0, 5) == 0);
            for (int i = 1; i < MAXC; i++) begin
                busy_a[i]  = ($urandom_range(0, 3) == 0);
                start_a[i] = ($urandom_range(0, 9) == 0);
                if (stuck) ov_a[i] = NUM_DST'($urandom_range(1, 15));
                else if ($urandom_range(0, 2) == 0) ov_a[i] = NUM_DST'($urandom_range(1, 15));
            end
            a = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : 0;
            run_tile(n, a, 0, ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(posedge clock);
        #1;
        chk("sb_empty", sbq.size(), 0);
        chk("monitor_idle", int'(m_active), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
